// File: rtl/cgra_job_scheduler.sv
// ---------------------------------------------------------------------------
// cgra_job_scheduler
//
// Collects kernel-launch requests from NREQ requesters, grants at most one per
// cycle in round-robin order into a small job FIFO, and plays each job onto the
// CGRA control port as two register writes (column mask, then kernel id). It
// then waits for the CGRA done interrupt. On completion the owning requester
// gets a one-cycle done pulse, and a shared irq pulses at the same time.
//
// Optional feature macro: CGRA_SCHED_TIMEOUT_EN
//   defined   : a 16-bit watchdog ends a job stuck in WAIT after TIMEOUT_CYCLES
//               cycles and flags it on err_o.
//   undefined : WAIT lasts until cgra_int_i, and err_o is tied low.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   req_valid_i/ready_o   per-requester request handshake (ready = granted)
//   req_kid_i             kernel id of requester i at [i*KID_W +: KID_W]
//   req_cols_i            column mask of requester i at [i*4 +: 4]
//   reg_valid_o/ready_i   register-write handshake towards the CGRA slave
//   reg_addr_o/wdata_o    write address/data, zero while reg_valid_o is low
//   cgra_int_i            CGRA kernel-done pulse
//   done_o                one-cycle completion pulse to the owning requester
//   err_o                 one-cycle timeout flag, coincides with done_o
//   irq_o                 one-cycle aggregate completion interrupt
//   busy_o                a job is in flight (FSM not IDLE)
//   fifo_level_o          registered FIFO occupancy
// ---------------------------------------------------------------------------
module cgra_job_scheduler #(
  parameter int unsigned NREQ           = 2,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned KID_W          = 4,
  parameter logic [31:0] CGRA_BASE      = 32'h0,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NREQ-1:0]               req_valid_i,
  output logic [NREQ-1:0]               req_ready_o,
  input  logic [NREQ*KID_W-1:0]         req_kid_i,
  input  logic [NREQ*4-1:0]             req_cols_i,
  output logic                          reg_valid_o,
  output logic [31:0]                   reg_addr_o,
  output logic [31:0]                   reg_wdata_o,
  input  logic                          reg_ready_i,
  input  logic                          cgra_int_i,
  output logic [NREQ-1:0]               done_o,
  output logic                          err_o,
  output logic                          irq_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned OWN_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_COLS = 3'd1;
  localparam logic [2:0] ST_WR_KID  = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam logic [31:0] ADDR_COLS = CGRA_BASE + 32'h8;
  localparam logic [31:0] ADDR_KID  = CGRA_BASE + 32'h4;

  logic [OWN_W-1:0] rr_q;
  logic             grant_valid;
  logic [OWN_W-1:0] grant_idx;

  logic [OWN_W-1:0] fifo_own_q  [FIFO_DEPTH];
  logic [KID_W-1:0] fifo_kid_q  [FIFO_DEPTH];
  logic [3:0]       fifo_cols_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             fifo_full, fifo_empty, push, pop;

  logic [2:0]       state_q, state_d;
  logic [OWN_W-1:0] own_q;
  logic [KID_W-1:0] kid_q;
  logic [3:0]       cols_q;
  logic             wdog_expired;

  assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);

  // Round-robin search starting at the pointer. Fullness is judged on the
  // registered level only, so a pop in the same cycle never makes room.
  always_comb begin
    int idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < int'(NREQ); k++) begin
      idx = int'(rr_q) + k;
      if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
      if (!grant_valid && !fifo_full && req_valid_i[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = OWN_W'(idx);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      req_ready_o[i] = grant_valid && (grant_idx == OWN_W'(i));
    end
  end

  assign push = grant_valid;
  assign pop  = (state_q == ST_IDLE) && !fifo_empty;

  // FIFO payload storage needs no reset; only the pointers define contents.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_own_q[wr_ptr_q]  <= grant_idx;
      fifo_kid_q[wr_ptr_q]  <= req_kid_i[int'(grant_idx)*KID_W +: KID_W];
      fifo_cols_q[wr_ptr_q] <= req_cols_i[int'(grant_idx)*4 +: 4];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        rr_q     <= (grant_idx == OWN_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (!push && pop) level_q <= level_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (!fifo_empty) state_d = ST_WR_COLS;
      ST_WR_COLS: if (reg_ready_i) state_d = ST_WR_KID;
      ST_WR_KID:  if (reg_ready_i) state_d = ST_WAIT;
      // The interrupt wins over a watchdog expiry in the same cycle.
      ST_WAIT:    if (cgra_int_i || wdog_expired) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      own_q   <= '0;
      kid_q   <= '0;
      cols_q  <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        own_q  <= fifo_own_q[rd_ptr_q];
        kid_q  <= fifo_kid_q[rd_ptr_q];
        cols_q <= fifo_cols_q[rd_ptr_q];
      end
    end
  end

`ifdef CGRA_SCHED_TIMEOUT_EN
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wdog_q;
  logic        err_q;

  assign wdog_expired = (state_q == ST_WAIT) && (wdog_q == WDOG_LAST);

  // The watchdog restarts on the kid write that enters WAIT. err_q is set
  // only on the expiry transition, so it is high exactly during that DONE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if ((state_q == ST_WR_KID) && reg_ready_i) begin
        wdog_q <= '0;
      end else if ((state_q == ST_WAIT) && !cgra_int_i && !wdog_expired) begin
        wdog_q <= wdog_q + 16'd1;
      end
      err_q <= wdog_expired && !cgra_int_i;
    end
  end

  assign err_o = (state_q == ST_DONE) && err_q;
`else
  assign wdog_expired = 1'b0;
  assign err_o        = 1'b0;
`endif

  // Outputs decode straight from the state register, so an asynchronous
  // reset drops reg_valid_o immediately.
  always_comb begin
    reg_valid_o = 1'b0;
    reg_addr_o  = '0;
    reg_wdata_o = '0;
    if (state_q == ST_WR_COLS) begin
      reg_valid_o = 1'b1;
      reg_addr_o  = ADDR_COLS;
      reg_wdata_o = {28'b0, cols_q};
    end else if (state_q == ST_WR_KID) begin
      reg_valid_o = 1'b1;
      reg_addr_o  = ADDR_KID;
      reg_wdata_o = 32'(kid_q);
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      done_o[i] = (state_q == ST_DONE) && (own_q == OWN_W'(i));
    end
  end

  assign irq_o        = (state_q == ST_DONE);
  assign busy_o       = (state_q != ST_IDLE);
  assign fifo_level_o = level_q;

endmodule

// File: tb/tb_cgra_job_scheduler.sv
// ---------------------------------------------------------------------------
// tb_cgra_job_scheduler
//
// Self-checking bench for cgra_job_scheduler (NREQ=2, FIFO_DEPTH=4, KID_W=4,
// TIMEOUT_CYCLES=16). A transaction-level reference model (job queue plus
// per-job write/interrupt progress) checks every output each cycle, alongside
// a vector table for the single-job flow and hand-written corner sequences.
// Honours CGRA_SCHED_TIMEOUT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_cgra_job_scheduler;

  localparam int NREQ    = 2;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst_n;
  logic [1:0]  reqValid;
  logic [1:0]  reqReady;
  logic [7:0]  reqKid;
  logic [7:0]  reqCols;
  logic        regValid;
  logic [31:0] regAddr;
  logic [31:0] regWdata;
  logic        regReady;
  logic        cgraInt;
  logic [1:0]  done;
  logic        err;
  logic        irq;
  logic        busy;
  logic [2:0]  level;

  int testsRun    = 0;
  int testsFailed = 0;

  cgra_job_scheduler #(
    .NREQ(NREQ), .FIFO_DEPTH(DEPTH), .KID_W(4),
    .CGRA_BASE(32'h0), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(reqValid), .req_ready_o(reqReady),
    .req_kid_i(reqKid), .req_cols_i(reqCols),
    .reg_valid_o(regValid), .reg_addr_o(regAddr), .reg_wdata_o(regWdata),
    .reg_ready_i(regReady), .cgra_int_i(cgraInt),
    .done_o(done), .err_o(err), .irq_o(irq), .busy_o(busy),
    .fifo_level_o(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Inputs change 1 time unit after the rising edge and hold for the cycle.
  task automatic applyStimulus(input logic [1:0] v, input logic [7:0] k,
                               input logic [7:0] c, input logic rdy,
                               input logic it);
    @(posedge clk);
    #1;
    reqValid = v;
    reqKid   = k;
    reqCols  = c;
    regReady = rdy;
    cgraInt  = it;
  endtask

  task automatic assertReset();
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    reqValid = '0;
    reqKid   = '0;
    reqCols  = '0;
    regReady = 1'b0;
    cgraInt  = 1'b0;
  endtask

  task automatic releaseReset();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // ------------------------------------------------------------------------
  // Reference model: a queue of accepted jobs and the progress of the job at
  // the CGRA (column write done, kid write done, finished). Compared at every
  // falling edge, then advanced using the inputs of that cycle.
  // ------------------------------------------------------------------------
  typedef struct {
    int owner;
    int kid;
    int cols;
  } job_t;

  job_t jobQ[$];
  job_t cur;
  int   rrPtr;
  bit   active, colsDone, kidDone, finished, timedOut;
  int   waitCnt;

  always @(negedge clk) begin
    int   g;
    int   idx;
    bit   expValid;
    logic [31:0] expAddr, expData;
    logic [1:0]  expDone;
    bit   expIrq, expErr;
    job_t nj;
    if (!rst_n) begin
      jobQ.delete();
      rrPtr  = 0;
      active = 0;
      checkOutput("rst.regValid", 32'(regValid), 32'd0);
      checkOutput("rst.done", 32'(done), 32'd0);
      checkOutput("rst.irq", 32'(irq), 32'd0);
      checkOutput("rst.err", 32'(err), 32'd0);
      checkOutput("rst.busy", 32'(busy), 32'd0);
      checkOutput("rst.level", 32'(level), 32'd0);
    end else begin
      g = -1;
      if (jobQ.size() < DEPTH) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (rrPtr + k) % NREQ;
          if (g < 0 && reqValid[idx]) g = idx;
        end
      end
      expValid = 0; expAddr = 0; expData = 0; expDone = 0; expIrq = 0; expErr = 0;
      if (active) begin
        if (!colsDone) begin
          expValid = 1; expAddr = 32'h8; expData = 32'(cur.cols);
        end else if (!kidDone) begin
          expValid = 1; expAddr = 32'h4; expData = 32'(cur.kid);
        end else if (finished) begin
          expDone = 2'(1 << cur.owner); expIrq = 1; expErr = timedOut;
        end
      end
      checkOutput("model.reqReady", 32'(reqReady), (g >= 0) ? 32'(1 << g) : 32'd0);
      checkOutput("model.level", 32'(level), 32'(jobQ.size()));
      checkOutput("model.regValid", 32'(regValid), 32'(expValid));
      checkOutput("model.regAddr", regAddr, expAddr);
      checkOutput("model.regWdata", regWdata, expData);
      checkOutput("model.done", 32'(done), 32'(expDone));
      checkOutput("model.irq", 32'(irq), 32'(expIrq));
      checkOutput("model.err", 32'(err), 32'(expErr));
      checkOutput("model.busy", 32'(busy), 32'(active));

      if (!active) begin
        if (jobQ.size() > 0) begin
          cur = jobQ.pop_front();
          active = 1; colsDone = 0; kidDone = 0; finished = 0; timedOut = 0;
        end
      end else if (!colsDone) begin
        colsDone = regReady;
      end else if (!kidDone) begin
        if (regReady) begin
          kidDone = 1;
          waitCnt = 0;
        end
      end else if (!finished) begin
        if (cgraInt) finished = 1;
`ifdef CGRA_SCHED_TIMEOUT_EN
        else if (waitCnt == TIMEOUT - 1) begin
          finished = 1;
          timedOut = 1;
        end else waitCnt++;
`endif
      end else begin
        active = 0;
      end

      if (g >= 0) begin
        nj.owner = g;
        nj.kid   = int'(reqKid[g*4 +: 4]);
        nj.cols  = int'(reqCols[g*4 +: 4]);
        jobQ.push_back(nj);
        rrPtr = (g + 1) % NREQ;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Vector table: single job from requester 0, kid 3, cols 0101, interrupt
  // ten cycles after entering WAIT.
  // ------------------------------------------------------------------------
  typedef struct packed {
    logic [1:0]  valid;
    logic [7:0]  kid;
    logic [7:0]  cols;
    logic        ready;
    logic        intr;
    logic [1:0]  expReqReady;
    logic        expRegValid;
    logic [31:0] expAddr;
    logic [31:0] expWdata;
    logic [1:0]  expDone;
    logic        expIrq;
    logic        expBusy;
    logic [2:0]  expLevel;
  } vec_t;

  vec_t vecs[17];

  initial begin
    #2_000_000;
    $display("[TB] FAIL global-timeout: got still running, expected finished");
    $fatal(1, "[TB] simulation did not terminate");
  end

  initial begin
    int doneCount;
    rst_n = 1'b0; reqValid = '0; reqKid = '0; reqCols = '0;
    regReady = 1'b0; cgraInt = 1'b0;

    for (int i = 0; i < 17; i++) begin
      vecs[i] = '0;
      vecs[i].ready   = 1'b1;
      vecs[i].expBusy = (i >= 2 && i <= 15);
    end
    vecs[0].valid = 2'b01; vecs[0].kid = 8'h03; vecs[0].cols = 8'h05;
    vecs[0].expReqReady = 2'b01;
    vecs[1].expLevel = 3'd1;
    vecs[2].expRegValid = 1'b1; vecs[2].expAddr = 32'h8; vecs[2].expWdata = 32'h5;
    vecs[3].expRegValid = 1'b1; vecs[3].expAddr = 32'h4; vecs[3].expWdata = 32'h3;
    vecs[14].intr = 1'b1;
    vecs[15].expDone = 2'b01; vecs[15].expIrq = 1'b1;

    releaseReset();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].kid, vecs[i].cols, vecs[i].ready, vecs[i].intr);
      @(negedge clk);
      checkOutput($sformatf("vec%0d.reqReady", i), 32'(reqReady), 32'(vecs[i].expReqReady));
      checkOutput($sformatf("vec%0d.regValid", i), 32'(regValid), 32'(vecs[i].expRegValid));
      checkOutput($sformatf("vec%0d.regAddr", i), regAddr, vecs[i].expAddr);
      checkOutput($sformatf("vec%0d.regWdata", i), regWdata, vecs[i].expWdata);
      checkOutput($sformatf("vec%0d.done", i), 32'(done), 32'(vecs[i].expDone));
      checkOutput($sformatf("vec%0d.irq", i), 32'(irq), 32'(vecs[i].expIrq));
      checkOutput($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].expBusy));
      checkOutput($sformatf("vec%0d.level", i), 32'(level), 32'(vecs[i].expLevel));
    end

    // Contention: both requesters always valid, job stuck in WAIT.
    assertReset();
    releaseReset();
    for (int c = 0; c < 14; c++) begin
      applyStimulus(2'b11, 8'h21, 8'h3C, 1'b1, c == 10);
      @(negedge clk);
      if (c < 5)
        checkOutput($sformatf("rr.grant%0d", c), 32'(reqReady), (c % 2 == 0) ? 32'd1 : 32'd2);
      else if (c < 13)
        checkOutput($sformatf("rr.full%0d", c), 32'(reqReady), 32'd0);
      else
        checkOutput("rr.afterPop", 32'(reqReady), 32'd2);
      if (c >= 5 && c <= 12) checkOutput($sformatf("rr.level%0d", c), 32'(level), 32'd4);
      if (c == 11) checkOutput("rr.done", 32'(done), 32'd1);
      if (c == 13) checkOutput("rr.levelAfterPop", 32'(level), 32'd3);
    end

    // Backpressure on the column write plus a spurious interrupt in WR_COLS.
    assertReset();
    releaseReset();
    doneCount = 0;
    for (int c = 0; c < 16; c++) begin
      applyStimulus((c == 0) ? 2'b10 : 2'b00, 8'h90, 8'hA0,
                    !(c >= 2 && c <= 6), (c == 3 || c == 12));
      @(negedge clk);
      if (c >= 2 && c <= 7) begin
        checkOutput($sformatf("bp.valid%0d", c), 32'(regValid), 32'd1);
        checkOutput($sformatf("bp.addr%0d", c), regAddr, 32'h8);
        checkOutput($sformatf("bp.data%0d", c), regWdata, 32'hA);
      end
      if (c == 8) begin
        checkOutput("bp.kidAddr", regAddr, 32'h4);
        checkOutput("bp.kidData", regWdata, 32'h9);
      end
      checkOutput($sformatf("bp.done%0d", c), 32'(done), (c == 13) ? 32'd2 : 32'd0);
      if (done != 0) doneCount++;
    end
    checkOutput("bp.doneCount", 32'(doneCount), 32'd1);

    // Watchdog: no interrupt for the first job, second job queued behind it.
    assertReset();
    releaseReset();
`ifdef CGRA_SCHED_TIMEOUT_EN
    for (int c = 0; c < 23; c++) begin
      applyStimulus((c == 0) ? 2'b01 : (c == 1) ? 2'b10 : 2'b00, 8'h57, 8'h3F, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("to.done%0d", c), 32'(done), (c == 20) ? 32'd1 : 32'd0);
      checkOutput($sformatf("to.err%0d", c), 32'(err), 32'(c == 20));
      checkOutput($sformatf("to.irq%0d", c), 32'(irq), 32'(c == 20));
      if (c == 22) begin
        checkOutput("to.nextValid", 32'(regValid), 32'd1);
        checkOutput("to.nextData", regWdata, 32'h3);
      end
    end
`else
    for (int c = 0; c < 44; c++) begin
      applyStimulus((c == 0) ? 2'b01 : (c == 1) ? 2'b10 : 2'b00, 8'h57, 8'h3F, 1'b1, 1'b0);
      @(negedge clk);
      if (c >= 4) begin
        checkOutput($sformatf("noto.busy%0d", c), 32'(busy), 32'd1);
        checkOutput($sformatf("noto.done%0d", c), 32'(done), 32'd0);
      end
    end
`endif

    // Reset in WAIT with two jobs still queued.
    assertReset();
    releaseReset();
    for (int c = 0; c < 8; c++) begin
      applyStimulus((c == 0 || c == 2) ? 2'b01 : (c == 1) ? 2'b10 : 2'b00,
                    8'h42, 8'h21, 1'b1, 1'b0);
    end
    @(negedge clk);
    checkOutput("rstw.levelBefore", 32'(level), 32'd2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstw.levelAsync", 32'(level), 32'd0);
    checkOutput("rstw.busyAsync", 32'(busy), 32'd0);
    releaseReset();
    for (int c = 0; c < 10; c++) begin
      applyStimulus(2'b00, 8'h00, 8'h00, 1'b1, c % 3 == 0);
      @(negedge clk);
      checkOutput($sformatf("rstw.done%0d", c), 32'(done), 32'd0);
      checkOutput($sformatf("rstw.busy%0d", c), 32'(busy), 32'd0);
    end

    // Reset while a column write is stalled: reg_valid_o drops at once.
    applyStimulus(2'b01, 8'h01, 8'h0F, 1'b0, 1'b0);
    applyStimulus(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    applyStimulus(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("rstc.validBefore", 32'(regValid), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstc.validAsync", 32'(regValid), 32'd0);
    releaseReset();

    // Random traffic checked by the model alone.
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);
    end
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
